key_op_sequencer: RTL and testbench

- Sits between the four KEY_PRESS debouncers and the grid/game controller.
- Converts debounced key levels into frame-aligned, one-cycle operation pulses (op_keys) with auto-repeat, and generates the gravity drop tick.
- All activity is paced by draw_finish, so the grid controller receives at most one key operation and one drop per displayed frame.

---
 rtl/key_op_if.sv | 18 +
 rtl/key_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_key_op_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_op_if.sv
// Key/frame bus between the debounced keypad side and the grid controller.
interface key_op_if;
  logic [3:0] key_level;
  logic       draw_finish;
  logic       freeze;
  logic [3:0] op_keys;
  logic       drop_tick;

  modport master (
    output key_level, draw_finish, freeze,
    input  op_keys, drop_tick
  );

  modport slave (
    input  key_level, draw_finish, freeze,
    output op_keys, drop_tick
  );
endinterface

// File: rtl/key_op_sequencer.sv
// Frame-paced key operation sequencer with auto-repeat and gravity drop tick.
// Optional macro INPUT_SYNC_EN adds a 2-flop synchronizer on key_level.
module key_op_sequencer #(
  parameter int DELAY_FRAMES   = 12,
  parameter int REPEAT_FRAMES  = 4,
  parameter int GRAVITY_FRAMES = 30,
  parameter int FAST_FRAMES    = 3
) (
  input  logic     vga_clk,
  input  logic     rst,
  key_op_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  localparam logic [7:0] DLY_LAST = 8'(DELAY_FRAMES - 1);
  localparam logic [7:0] RPT_LAST = 8'(REPEAT_FRAMES - 1);
  localparam logic [7:0] GRV_LAST = 8'(GRAVITY_FRAMES - 1);
  localparam logic [7:0] FST_LAST = 8'(FAST_FRAMES - 1);

  logic [3:0] key_s;

`ifdef INPUT_SYNC_EN
  logic [3:0] sync_p0, sync_p1;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.key_level;
      sync_p1 <= sync_p0;
    end
  end

  assign key_s = sync_p1;
`else
  assign key_s = bus.key_level;
`endif

  logic       df_q;
  logic       tick;
  logic [3:0] key_q;
  logic [3:0] press_latch;
  logic [3:0] pressed;
  state_t     st     [4];
  state_t     st_nxt [4];
  logic [7:0] cnt     [4];
  logic [7:0] cnt_nxt [4];
  logic [3:0] req;
  logic [3:0] grant;
  logic [7:0] g, g_nxt, g_last;
  logic       drop_nxt;

  assign tick    = bus.draw_finish & ~df_q;
  assign pressed = key_s | press_latch;

  // Left+right together cancel each other; then up > left > right > down.
  function automatic logic [3:0] arbitrate(input logic [3:0] r);
    logic [3:0] m;
    m = r;
    if (m[2] & m[3]) m[3:2] = 2'b00;
    if (m[0])      return 4'b0001;
    else if (m[2]) return 4'b0100;
    else if (m[3]) return 4'b1000;
    else if (m[1]) return 4'b0010;
    else           return 4'b0000;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      req[i]     = 1'b0;
      case (st[i])
        S_IDLE: begin
          if (pressed[i]) begin
            req[i]     = 1'b1;
            st_nxt[i]  = S_DELAY;
            cnt_nxt[i] = '0;
          end
        end
        S_DELAY: begin
          if (!key_s[i]) begin
            st_nxt[i]  = S_IDLE;
            cnt_nxt[i] = '0;
          end else if (i != 0) begin
            // Rotate (bit 0) parks here while held: it never auto-repeats.
            if (cnt[i] == DLY_LAST) begin
              req[i]     = 1'b1;
              st_nxt[i]  = S_REPEAT;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 8'd1;
            end
          end
        end
        S_REPEAT: begin
          if (!key_s[i]) begin
            st_nxt[i]  = S_IDLE;
            cnt_nxt[i] = '0;
          end else if (cnt[i] == RPT_LAST) begin
            req[i]     = 1'b1;
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 8'd1;
          end
        end
        default: begin
          st_nxt[i]  = S_IDLE;
          cnt_nxt[i] = '0;
        end
      endcase
    end
  end

  assign grant = arbitrate(req);

  // >= lets a switch to the shorter fast limit fire at once.
  always_comb begin
    g_last   = key_s[1] ? FST_LAST : GRV_LAST;
    drop_nxt = 1'b0;
    g_nxt    = g + 8'd1;
    if (g >= g_last) begin
      drop_nxt = 1'b1;
      g_nxt    = '0;
    end
    if (grant[1]) begin
      drop_nxt = 1'b0;
      g_nxt    = '0;
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
    end else if (bus.freeze) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Output stage: pulses are registered and live for exactly one cycle.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      df_q          <= 1'b1;
      key_q         <= '0;
      press_latch   <= '0;
      g             <= '0;
      bus.op_keys   <= '0;
      bus.drop_tick <= 1'b0;
    end else begin
      df_q          <= bus.draw_finish;
      key_q         <= key_s;
      bus.op_keys   <= '0;
      bus.drop_tick <= 1'b0;
      if (bus.freeze) begin
        press_latch <= '0;
        g           <= '0;
      end else if (tick) begin
        press_latch   <= '0;
        g             <= g_nxt;
        bus.op_keys   <= grant;
        bus.drop_tick <= drop_nxt;
      end else begin
        press_latch <= press_latch | (key_s & ~key_q);
      end
    end
  end

endmodule

// File: tb/tb_key_op_sequencer.sv
// Directed bench for key_op_sequencer with default frame parameters.
module tb_key_op_sequencer;

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  key_op_if bus ();

  key_op_sequencer dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic do_reset(input logic df);
    @(negedge vga_clk);
    rst             = 1'b1;
    bus.key_level   = 4'b0000;
    bus.freeze      = 1'b0;
    bus.draw_finish = df;
    repeat (2) @(negedge vga_clk);
    rst = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic set_keys(input logic [3:0] k);
    bus.key_level = k;
    repeat (4) @(negedge vga_clk);
  endtask

  // One frame starting at a negedge; ops/drp are sampled right after the tick,
  // act counts every sampled cycle in the frame with any output high.
  task automatic do_frame(output logic [3:0] ops, output logic drp, output int act);
    act = 0;
    bus.draw_finish = 1'b1;
    @(negedge vga_clk);
    ops = bus.op_keys;
    drp = bus.drop_tick;
    if (ops != 4'b0000 || drp) act++;
    for (int c = 0; c < 7; c++) begin
      @(negedge vga_clk);
      if (c == 1) bus.draw_finish = 1'b0;
      if (bus.op_keys != 4'b0000 || bus.drop_tick) act++;
    end
  endtask

  task automatic test_reset;
    logic [3:0] ops;
    logic       drp;
    int         act;
    int         bad;
    int         drops;
    do_reset(1'b1);
    checks++;
    if (bus.op_keys !== 4'b0000 || bus.drop_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b expected 0000/0", bus.op_keys, bus.drop_tick);
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge vga_clk);
      if (bus.op_keys != 4'b0000 || bus.drop_tick) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_df_high_no_pulse got %0d active cycles expected 0", bad);
    end
    bus.draw_finish = 1'b0;
    repeat (2) @(negedge vga_clk);
    drops = 0;
    for (int f = 1; f <= 29; f++) begin
      do_frame(ops, drp, act);
      if (drp) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL gravity_early got %0d drops expected 0", drops);
    end
    do_frame(ops, drp, act);
    checks++;
    if (drp !== 1'b1 || act != 1) begin
      errors++;
      $display("FAIL gravity_tick30 got drop=%b width=%0d expected drop=1 width=1", drp, act);
    end
  endtask

  task automatic test_left_repeat;
    logic [3:0] ops, exp;
    logic       drp;
    int         act;
    do_reset(1'b0);
    set_keys(4'b0100);
    for (int f = 1; f <= 21; f++) begin
      exp = (f == 1 || f == 13 || f == 17 || f == 21) ? 4'b0100 : 4'b0000;
      do_frame(ops, drp, act);
      checks++;
      if (ops !== exp || act != ((exp != 4'b0000) ? 1 : 0)) begin
        errors++;
        $display("FAIL left_repeat_tick%0d got %b width=%0d expected %b", f, ops, act, exp);
      end
    end
    set_keys(4'b0000);
    for (int f = 22; f <= 26; f++) begin
      do_frame(ops, drp, act);
      checks++;
      if (ops !== 4'b0000) begin
        errors++;
        $display("FAIL left_release_tick%0d got %b expected 0000", f, ops);
      end
    end
  endtask

  task automatic test_up_no_repeat;
    logic [3:0] ops;
    logic       drp;
    int         act;
    int         n_up;
    int         n_other;
    do_reset(1'b0);
    set_keys(4'b0001);
    n_up = 0;
    n_other = 0;
    for (int f = 1; f <= 50; f++) begin
      do_frame(ops, drp, act);
      if (f == 1) begin
        checks++;
        if (ops !== 4'b0001) begin
          errors++;
          $display("FAIL up_first got %b expected 0001", ops);
        end
      end
      if (ops == 4'b0001) n_up++;
      else if (ops != 4'b0000) n_other++;
    end
    checks++;
    if (n_up != 1 || n_other != 0) begin
      errors++;
      $display("FAIL up_hold50 got %0d up / %0d other expected 1 / 0", n_up, n_other);
    end
  endtask

  task automatic test_tap_and_cancel;
    logic [3:0] ops;
    logic       drp;
    int         act;
    do_reset(1'b0);
    bus.key_level = 4'b1000;
    repeat (3) @(negedge vga_clk);
    set_keys(4'b0000);
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b1000) begin
      errors++;
      $display("FAIL right_tap got %b expected 1000", ops);
    end
    do_frame(ops, drp, act);
    do_reset(1'b0);
    set_keys(4'b1100);
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b0000) begin
      errors++;
      $display("FAIL left_right_cancel got %b expected 0000", ops);
    end
    set_keys(4'b0000);
  endtask

  task automatic test_down_gravity;
    logic [3:0] ops;
    logic       drp;
    int         act;
    do_reset(1'b0);
    for (int f = 0; f < 10; f++) do_frame(ops, drp, act);
    set_keys(4'b0010);
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b0010 || drp !== 1'b0) begin
      errors++;
      $display("FAIL down_first got %b/%b expected 0010/0", ops, drp);
    end
    for (int f = 1; f <= 3; f++) begin
      do_frame(ops, drp, act);
      checks++;
      if (drp !== (f == 3) || ops !== 4'b0000) begin
        errors++;
        $display("FAIL down_fast_drop%0d got %b/%b expected 0000/%b", f, ops, drp, f == 3);
      end
    end
    set_keys(4'b0000);
  endtask

  task automatic test_freeze_and_rst;
    logic [3:0] ops;
    logic       drp;
    int         act;
    do_reset(1'b0);
    set_keys(4'b1000);
    for (int f = 1; f <= 16; f++) do_frame(ops, drp, act);
    bus.freeze = 1'b1;
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b0000 || act != 0) begin
      errors++;
      $display("FAIL freeze_suppress got %b width=%0d expected 0000", ops, act);
    end
    do_frame(ops, drp, act);
    bus.freeze = 1'b0;
    repeat (2) @(negedge vga_clk);
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b1000) begin
      errors++;
      $display("FAIL freeze_release_fresh got %b expected 1000", ops);
    end
    for (int f = 2; f <= 16; f++) do_frame(ops, drp, act);
    bus.draw_finish = 1'b1;
    @(negedge vga_clk);
    checks++;
    if (bus.op_keys !== 4'b1000) begin
      errors++;
      $display("FAIL repeat_before_rst got %b expected 1000", bus.op_keys);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.op_keys !== 4'b0000 || bus.drop_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_cut got %b/%b expected 0000/0", bus.op_keys, bus.drop_tick);
    end
    @(negedge vga_clk);
    bus.draw_finish = 1'b0;
    @(negedge vga_clk);
    rst = 1'b0;
    repeat (2) @(negedge vga_clk);
    do_frame(ops, drp, act);
    checks++;
    if (ops !== 4'b1000) begin
      errors++;
      $display("FAIL rst_fsm_idle got %b expected 1000", ops);
    end
    set_keys(4'b0000);
  endtask

  initial begin
    bus.key_level   = 4'b0000;
    bus.draw_finish = 1'b0;
    bus.freeze      = 1'b0;
    test_reset;
    test_left_repeat;
    test_up_no_repeat;
    test_tap_and_cancel;
    test_down_gravity;
    test_freeze_and_rst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
